// File: rtl/nav_pkg.sv
// Shared types and speed constants for the maze navigation controller.
// NAV_FAST_SIM_EN selects the coarse speed increment used for fast simulation.
package nav_pkg;

  typedef enum logic [2:0] {
    NAV_IDLE     = 3'd0,
    NAV_HDNG     = 3'd1,
    NAV_RAMP     = 3'd2,
    NAV_DEC      = 3'd3,
    NAV_DEC_FAST = 3'd4
  } nav_state_t;

  localparam logic [10:0] MAX_FRWRD      = 11'h2A0;
  localparam logic [10:0] FRWRD_INC_FAST = 11'h018;
  localparam logic [10:0] FRWRD_INC_SLOW = 11'h002;

`ifdef NAV_FAST_SIM_EN
  localparam logic [10:0] FRWRD_INC = FRWRD_INC_FAST;
`else
  localparam logic [10:0] FRWRD_INC = FRWRD_INC_SLOW;
`endif

endpackage

// File: rtl/frwrd_ramp.sv
// Forward-speed datapath: saturating ramp up and floored ramp down,
// advanced once per heading sample.
import nav_pkg::*;

module frwrd_ramp (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc_en,
  input  logic        dec_en,
  input  logic        dec_fast,
  input  logic        step,
  output logic [10:0] frwrd_spd,
  output logic        done
);

  logic [11:0] inc12;
  logic [11:0] dec_amt;
  logic [11:0] sum;
  logic [11:0] diff;
  logic [10:0] sat;
  logic        floor_hit;

  assign inc12   = {1'b0, FRWRD_INC};
  assign dec_amt = dec_fast ? (inc12 << 2) : (inc12 << 1);
  assign sum     = {1'b0, frwrd_spd} + inc12;
  assign diff    = {1'b0, frwrd_spd} - dec_amt;
  assign sat     = (sum >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : sum[10:0];

  // a step that would reach or cross zero ends the move instead
  assign floor_hit = {1'b0, frwrd_spd} <= dec_amt;
  assign done      = dec_en & step & floor_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      frwrd_spd <= 11'h000;
    end else if (clr) begin
      frwrd_spd <= 11'h000;
    end else if (step) begin
      if (inc_en) begin
        frwrd_spd <= sat;
      end else if (dec_en) begin
        frwrd_spd <= floor_hit ? 11'h000 : diff[10:0];
      end
    end
  end

endmodule

// File: rtl/navigate.sv
// Maze navigation sequencer: heading turns, forward ramp, opening/obstacle stops.
// Define NAV_FAST_SIM_EN for the coarse simulation speed increment.
import nav_pkg::*;

module navigate (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_hdng,
  input  logic        strt_mv,
  input  logic        stp_lft,
  input  logic        stp_rght,
  input  logic        hdng_rdy,
  input  logic        at_hdng,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        moving,
  output logic [10:0] frwrd_spd,
  output logic        mv_cmplt,
  output logic        en_fusion
);

  nav_state_t state;
  logic       stp_lft_q;
  logic       stp_rght_q;
  logic       lft_q;
  logic       rght_q;
  logic       opn_hit;
  logic       ramp_done;
  logic       clr;
  logic       inc_en;
  logic       dec_en;
  logic       dec_fast;

  assign opn_hit = (lft_opn & ~lft_q & stp_lft_q)
                 | (rght_opn & ~rght_q & stp_rght_q);

  assign moving    = (state != NAV_IDLE);
  assign clr       = (state == NAV_IDLE) | (state == NAV_HDNG);
  assign inc_en    = (state == NAV_RAMP);
  assign dec_fast  = (state == NAV_DEC_FAST);
  assign dec_en    = (state == NAV_DEC) | dec_fast;
  assign en_fusion = frwrd_spd > (MAX_FRWRD >> 1);

  frwrd_ramp u_ramp (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc_en    (inc_en),
    .dec_en    (dec_en),
    .dec_fast  (dec_fast),
    .step      (hdng_rdy),
    .frwrd_spd (frwrd_spd),
    .done      (ramp_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NAV_IDLE;
      mv_cmplt   <= 1'b0;
      stp_lft_q  <= 1'b0;
      stp_rght_q <= 1'b0;
      lft_q      <= 1'b0;
      rght_q     <= 1'b0;
    end else begin
      mv_cmplt <= 1'b0;
      lft_q    <= lft_opn;
      rght_q   <= rght_opn;
      unique case (state)
        NAV_IDLE: begin
          if (strt_hdng) begin
            state <= NAV_HDNG;
          end else if (strt_mv) begin
            state      <= NAV_RAMP;
            stp_lft_q  <= stp_lft;
            stp_rght_q <= stp_rght;
          end
        end
        NAV_HDNG: begin
          if (at_hdng) begin
            state    <= NAV_IDLE;
            mv_cmplt <= 1'b1;
          end
        end
        NAV_RAMP: begin
          if (!frwrd_opn) begin
            state <= NAV_DEC_FAST;
          end else if (opn_hit) begin
            state <= NAV_DEC;
          end
        end
        NAV_DEC: begin
          if (ramp_done) begin
            state    <= NAV_IDLE;
            mv_cmplt <= 1'b1;
          end else if (!frwrd_opn) begin
            state <= NAV_DEC_FAST;
          end
        end
        NAV_DEC_FAST: begin
          if (ramp_done) begin
            state    <= NAV_IDLE;
            mv_cmplt <= 1'b1;
          end
        end
        default: state <= NAV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_navigate.sv
// Directed bench for navigate: turns, ramps, opening and obstacle stops,
// ignore rules and mid-move reset. Follows NAV_FAST_SIM_EN for the increment.
module tb_navigate;

`ifdef NAV_FAST_SIM_EN
  localparam int INC = 32'h018;
`else
  localparam int INC = 32'h002;
`endif
  localparam int MAX = 32'h2A0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_hdng = 1'b0;
  logic        strt_mv = 1'b0;
  logic        stp_lft = 1'b0;
  logic        stp_rght = 1'b0;
  logic        hdng_rdy = 1'b0;
  logic        at_hdng = 1'b0;
  logic        lft_opn = 1'b0;
  logic        rght_opn = 1'b0;
  logic        frwrd_opn = 1'b1;
  logic        moving;
  logic [10:0] frwrd_spd;
  logic        mv_cmplt;
  logic        en_fusion;

  int checks = 0;
  int errors = 0;
  int exp_spd = 0;
  int bad;

  navigate dut (
    .clk       (clk),
    .rst       (rst),
    .strt_hdng (strt_hdng),
    .strt_mv   (strt_mv),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .hdng_rdy  (hdng_rdy),
    .at_hdng   (at_hdng),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .frwrd_opn (frwrd_opn),
    .moving    (moving),
    .frwrd_spd (frwrd_spd),
    .mv_cmplt  (mv_cmplt),
    .en_fusion (en_fusion)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ramp(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      hdng_rdy = 1'b1;
      tick();
      exp_spd = (exp_spd + INC >= MAX) ? MAX : exp_spd + INC;
      chk({tag, "_spd"}, {21'd0, frwrd_spd}, exp_spd);
      chk({tag, "_fus"}, {31'd0, en_fusion}, {31'd0, exp_spd > MAX / 2});
    end
    hdng_rdy = 1'b0;
  endtask

  task automatic dec_run(input int d, input string tag);
    int n;
    int want;
    n = 0;
    want = (exp_spd + d - 1) / d;
    while (exp_spd > 0 && n < 2000) begin
      hdng_rdy = 1'b1;
      tick();
      n++;
      exp_spd = (exp_spd <= d) ? 0 : exp_spd - d;
      chk({tag, "_spd"}, {21'd0, frwrd_spd}, exp_spd);
      chk({tag, "_cmplt"}, {31'd0, mv_cmplt}, {31'd0, exp_spd == 0});
    end
    hdng_rdy = 1'b0;
    chk({tag, "_nsteps"}, n, want);
    chk({tag, "_idle"}, {31'd0, moving}, 0);
    tick();
    chk({tag, "_cmplt_once"}, {31'd0, mv_cmplt}, 0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_moving", {31'd0, moving}, 0);
    chk("rst_spd", {21'd0, frwrd_spd}, 0);
    chk("rst_cmplt", {31'd0, mv_cmplt}, 0);
    chk("rst_fus", {31'd0, en_fusion}, 0);

    // heading turn
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      hdng_rdy = i[0];
      tick();
      if (moving !== 1'b1 || frwrd_spd !== 11'd0 || mv_cmplt !== 1'b0)
        bad++;
    end
    hdng_rdy = 1'b0;
    chk("hdng_hold", bad, 0);
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    chk("hdng_cmplt", {31'd0, mv_cmplt}, 1);
    chk("hdng_idle", {31'd0, moving}, 0);
    tick();
    chk("hdng_cmplt_once", {31'd0, mv_cmplt}, 0);

    // ramp with ignore rules, then obstacle stop from full speed
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    exp_spd = 0;
    chk("ramp_moving", {31'd0, moving}, 1);
    tick();
    tick();
    chk("ramp_no_step", {21'd0, frwrd_spd}, 0);
    ramp(5, "ramp_a");
    strt_hdng = 1'b1;
    tick();
    strt_hdng = 1'b0;
    chk("ign_hdng_mv", {31'd0, moving}, 1);
    chk("ign_hdng_spd", {21'd0, frwrd_spd}, exp_spd);
    stp_lft = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    ramp(MAX / INC - 5, "ramp_b");
    chk("ramp_max", {21'd0, frwrd_spd}, MAX);
    ramp(3, "ramp_sat");
    lft_opn = 1'b1;
    tick();
    lft_opn = 1'b0;
    ramp(2, "ign_lft");
    chk("ign_lft_max", {21'd0, frwrd_spd}, MAX);
    stp_lft = 1'b0;
    frwrd_opn = 1'b0;
    tick();
    frwrd_opn = 1'b1;
    dec_run(4 * INC, "obst_max");

    // opening stop on the left
    stp_lft = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    stp_lft = 1'b0;
    exp_spd = 0;
    ramp(MAX / INC, "open_ramp");
    lft_opn = 1'b1;
    tick();
    lft_opn = 1'b0;
    chk("open_hold", {21'd0, frwrd_spd}, MAX);
    dec_run(2 * INC, "open_dec");

    // right opening into DEC, then obstacle forces DEC_FAST
    stp_rght = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    stp_rght = 1'b0;
    exp_spd = 0;
    ramp(20, "rght_ramp");
    rght_opn = 1'b1;
    tick();
    rght_opn = 1'b0;
    hdng_rdy = 1'b1;
    tick();
    hdng_rdy = 1'b0;
    exp_spd = exp_spd - 2 * INC;
    chk("rght_dec", {21'd0, frwrd_spd}, exp_spd);
    frwrd_opn = 1'b0;
    tick();
    frwrd_opn = 1'b1;
    dec_run(4 * INC, "rght_fast");

    // obstacle during ramp at 0x0F0
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    exp_spd = 0;
    ramp(32'h0F0 / INC, "obst_ramp");
    chk("obst_start", {21'd0, frwrd_spd}, 32'h0F0);
    frwrd_opn = 1'b0;
    tick();
    frwrd_opn = 1'b1;
    chk("obst_hold", {21'd0, frwrd_spd}, 32'h0F0);
    dec_run(4 * INC, "obst_dec");

    // simultaneous start requests: heading wins
    strt_hdng = 1'b1;
    strt_mv = 1'b1;
    tick();
    strt_hdng = 1'b0;
    strt_mv = 1'b0;
    hdng_rdy = 1'b1;
    tick();
    tick();
    hdng_rdy = 1'b0;
    chk("both_moving", {31'd0, moving}, 1);
    chk("both_spd", {21'd0, frwrd_spd}, 0);
    at_hdng = 1'b1;
    tick();
    at_hdng = 1'b0;
    chk("both_cmplt", {31'd0, mv_cmplt}, 1);

    // reset mid-move at 0x120
    tick();
    strt_mv = 1'b1;
    tick();
    strt_mv = 1'b0;
    exp_spd = 0;
    ramp(32'h120 / INC, "mid_ramp");
    chk("mid_start", {21'd0, frwrd_spd}, 32'h120);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_moving", {31'd0, moving}, 0);
    chk("mid_spd", {21'd0, frwrd_spd}, 0);
    chk("mid_cmplt", {31'd0, mv_cmplt}, 0);
    chk("mid_fus", {31'd0, en_fusion}, 0);
    hdng_rdy = 1'b1;
    tick();
    hdng_rdy = 1'b0;
    chk("mid_idle_spd", {21'd0, frwrd_spd}, 0);
    chk("mid_idle_cmplt", {31'd0, mv_cmplt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/navigate.md
NAVIGATE -- requirements
Module: navigate

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port strt_hdng, input, 1 bit: single-cycle pulse requesting a heading change.
REQ-004 SHALL have port strt_mv, input, 1 bit: single-cycle pulse requesting a forward move.
REQ-005 SHALL have ports stp_lft and stp_rght, input, 1 bit each: stop the move at a left/right opening; sampled when strt_mv is accepted.
REQ-006 SHALL have port hdng_rdy, input, 1 bit: heading-sample strobe; paces every speed step.
REQ-007 SHALL have port at_hdng, input, 1 bit: heading error inside tolerance, driven by the heading controller.
REQ-008 SHALL have ports lft_opn, rght_opn and frwrd_opn, input, 1 bit each: maze opening sensors.
REQ-009 SHALL have port moving, output, 1 bit: enables the heading controller.
REQ-010 SHALL have port frwrd_spd, output, 11 bits unsigned: forward-speed command to the heading controller.
REQ-011 SHALL have port mv_cmplt, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port en_fusion, output, 1 bit: high while frwrd_spd > MAX_FRWRD/2.

Function
REQ-013 SHALL implement states IDLE, HDNG, RAMP, DEC, DEC_FAST.
REQ-014 SHALL, in IDLE, hold moving=0 and frwrd_spd=0; strt_hdng → HDNG; strt_mv → RAMP; strt_hdng wins if both arrive together.
REQ-015 SHALL ignore strt_hdng and strt_mv in every state except IDLE.
REQ-016 SHALL latch stp_lft and stp_rght on strt_mv acceptance; later changes have no effect on the current move.
REQ-017 SHALL, in HDNG, drive moving=1 and frwrd_spd=0; at_hdng=1 → IDLE with mv_cmplt pulsed for one cycle on that transition.
REQ-018 SHALL, in RAMP/DEC/DEC_FAST, drive moving=1.
REQ-019 SHALL, in RAMP, add FRWRD_INC to frwrd_spd on each hdng_rdy, saturating at MAX_FRWRD; no change without hdng_rdy.
REQ-020 SHALL detect rising edges of lft_opn and rght_opn using one-cycle-delayed copies; edge = current 1 and previous 0.
REQ-021 SHALL, in RAMP, go to DEC on a lft_opn rising edge with stp_lft latched, or a rght_opn rising edge with stp_rght latched.
REQ-022 SHALL, in RAMP or DEC, go to DEC_FAST when frwrd_opn=0; this takes priority over REQ-021.
REQ-023 SHALL, on each hdng_rdy, subtract 2*FRWRD_INC from frwrd_spd in DEC and 4*FRWRD_INC in DEC_FAST.
REQ-024 SHALL, when frwrd_spd ≤ the decrement at a hdng_rdy, load 0, go to IDLE and pulse mv_cmplt; frwrd_spd never wraps below 0.
REQ-025 SHALL generate mv_cmplt registered (asserted the cycle after the transition edge), high exactly one cycle.
REQ-026 SHALL treat frwrd_spd as unsigned 11 bits; the saturating add and floor-at-zero subtract are computed 12 bits wide.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, force state IDLE, frwrd_spd=0, moving=0, mv_cmplt=0, en_fusion=0, latched stop flags=0 and edge-detect flops=0, including mid-move.

Configuration
REQ-028 SHALL, with NAV_FAST_SIM_EN defined, use FRWRD_INC=11'h018; without it, FRWRD_INC=11'h002; MAX_FRWRD=11'h2A0 in both cases.

Structure
REQ-029 SHALL place the state enum nav_state_t, MAX_FRWRD and both FRWRD_INC values in package nav_pkg.
REQ-030 SHALL implement the saturating ramp/decrement datapath as sub-module frwrd_ramp; the FSM and edge detection stay in navigate.

Verification
REQ-031 SHALL test heading turn: strt_hdng; at_hdng=1 after 50 cycles → moving=1 throughout, frwrd_spd=0, mv_cmplt pulses once, then IDLE.
REQ-032 SHALL test ramp with NAV_FAST_SIM_EN: strt_mv plus 28 hdng_rdy → frwrd_spd=0x2A0; further hdng_rdy keep it at 0x2A0; en_fusion rises after the 15th step (0x168 > 0x150).
REQ-033 SHALL test opening stop: stp_lft=1, ramp to 0x2A0, lft_opn 0→1 → DEC; frwrd_spd falls by 0x30 per hdng_rdy; mv_cmplt on the 14th step.
REQ-034 SHALL test obstacle: during RAMP at 0x0F0, frwrd_opn=0 → DEC_FAST; steps of 0x60 give 0x090, 0x030, then 0 with mv_cmplt.
REQ-035 SHALL test the ignore rules: lft_opn edge with stp_lft=0 → no DEC; strt_hdng during RAMP → ignored; strt_hdng and strt_mv together in IDLE → HDNG.
REQ-036 SHALL test reset mid-move: rst=1 for 1 cycle at frwrd_spd=0x120 → next cycle all outputs 0 in IDLE, no mv_cmplt.
